// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch unit with a registered IF output stage.
//
// Purpose:
//   Issues one instruction memory request per cycle, keeps the request
//   address stable until memory answers, and hands fetched words to decode
//   through the IF output register. If decode stalls while a response
//   arrives, a one-entry skid buffer holds that response. A redirect either
//   retargets the pc straight away, or waits for an outstanding access to
//   finish and drops its response.
//
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   stall           - decode is not taking the IF output register this cycle
//   redirect_valid  - branch/jump redirect request
//   redirect_pc     - redirect target (bits [1:0] forced to zero)
//   imem_req        - registered instruction memory request
//   imem_addr       - request address (the pc register)
//   imem_ready      - memory response strobe
//   imem_rdata      - fetched instruction word
//   if_valid        - IF output register holds a live instruction
//   if_pc           - address of the instruction in if_instr
//   if_instr        - instruction word presented to decode

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  logic [1:0]  state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic [31:0] pending_q,   pending_d;
  logic        skidValid_q, skidValid_d;
  logic [31:0] skidPc_q,    skidPc_d;
  logic [31:0] skidInstr_q, skidInstr_d;
  logic        ifValid_q,   ifValid_d;
  logic [31:0] ifPc_q,      ifPc_d;
  logic [31:0] ifInstr_q,   ifInstr_d;
  logic        imemReq_q,   imemReq_d;

  logic [31:0] redirTarget;
  logic [31:0] pcPlus4;
  logic        outFree;

  // Next-state logic. The output register keeps its contents only while
  // decode stalls; otherwise it is treated as consumed and drops unless a
  // new instruction lands in it this cycle.
  always_comb begin
    redirTarget = {redirect_pc[31:2], 2'b00};
    pcPlus4     = pc_q + 32'd4;
    outFree     = !ifValid_q || !stall;

    state_d     = state_q;
    pc_d        = pc_q;
    pending_d   = pending_q;
    skidValid_d = skidValid_q;
    skidPc_d    = skidPc_q;
    skidInstr_d = skidInstr_q;
    ifValid_d   = ifValid_q && stall;
    ifPc_d      = ifPc_q;
    ifInstr_d   = ifInstr_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_valid) pc_d = redirTarget;
      end
      FETCH: begin
        if (redirect_valid) begin
          // A response that arrives with the redirect belongs to the old
          // path and is dropped; an outstanding access must finish first.
          if (imem_ready) begin
            pc_d = redirTarget;
          end else begin
            pending_d = redirTarget;
            state_d   = DISCARD;
          end
        end else if (imem_ready) begin
          pc_d = pcPlus4;
          if (outFree) begin
            ifValid_d = 1'b1;
            ifPc_d    = pc_q;
            ifInstr_d = imem_rdata;
          end else begin
            skidValid_d = 1'b1;
            skidPc_d    = pc_q;
            skidInstr_d = imem_rdata;
            state_d     = HOLD;
          end
        end
      end
      DISCARD: begin
        // The latest redirect always wins, even in the cycle the stale
        // response comes back.
        if (redirect_valid) pending_d = redirTarget;
        if (imem_ready) begin
          pc_d    = redirect_valid ? redirTarget : pending_q;
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirTarget;
          state_d = FETCH;
        end else if (!stall && skidValid_q) begin
          ifValid_d   = 1'b1;
          ifPc_d      = skidPc_q;
          ifInstr_d   = skidInstr_q;
          skidValid_d = 1'b0;
          state_d     = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      ifValid_d   = 1'b0;
      skidValid_d = 1'b0;
    end

    imemReq_d = (state_d == FETCH) || (state_d == DISCARD);
  end

  // State registers; reset abandons any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pending_q   <= 32'd0;
      skidValid_q <= 1'b0;
      skidPc_q    <= 32'd0;
      skidInstr_q <= 32'd0;
      ifValid_q   <= 1'b0;
      ifPc_q      <= 32'd0;
      ifInstr_q   <= 32'd0;
      imemReq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      skidValid_q <= skidValid_d;
      skidPc_q    <= skidPc_d;
      skidInstr_q <= skidInstr_d;
      ifValid_q   <= ifValid_d;
      ifPc_q      <= ifPc_d;
      ifInstr_q   <= ifInstr_d;
      imemReq_q   <= imemReq_d;
    end
  end

  assign imem_req  = imemReq_q;
  assign imem_addr = pc_q;
  assign if_valid  = ifValid_q;
  assign if_pc     = ifPc_q;
  assign if_instr  = ifInstr_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 stall  input  1  downstream not accepting the IF output register this cycle.
REQ-005 redirect_valid  input  1  branch/jump redirect request.
REQ-006 redirect_pc  input  32  redirect target; bits [1:0] SHALL be ignored and treated as 0.
REQ-007 imem_req  output  1  instruction memory request, registered.
REQ-008 imem_addr  output  32  request address, equal to the internal pc register.
REQ-009 imem_ready  input  1  memory response; imem_rdata is valid only in a cycle where imem_req=1 and imem_ready=1.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 if_valid  output  1  IF output register holds a live instruction.
REQ-012 if_pc  output  32  address of the instruction in if_instr.
REQ-013 if_instr  output  32  instruction word presented to decode.

Function
REQ-014 The block SHALL implement four states: IDLE, FETCH, DISCARD, HOLD; imem_req SHALL be 1 exactly in FETCH and DISCARD.
REQ-015 Once imem_req=1, imem_addr SHALL stay stable until the cycle imem_ready=1.
REQ-016 IDLE: entered only from reset; next cycle goes to FETCH (redirect in IDLE sets pc to redirect_pc first).
REQ-017 FETCH, imem_ready=1, no redirect, output register free (if_valid=0 or stall=0): capture if_valid<=1, if_pc<=pc, if_instr<=imem_rdata, pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); stay FETCH.
REQ-018 FETCH, imem_ready=1, no redirect, if_valid=1 and stall=1: store response in a one-entry skid buffer (pc, word), pc<=pc+4, go HOLD.
REQ-019 HOLD: imem_req=0; when stall=0, skid moves into the output register (if_valid=1) and state returns to FETCH.
REQ-020 Sustained throughput SHALL be one instruction per cycle when imem_ready is held high and stall=0.
REQ-021 redirect_valid=1 in any state SHALL clear if_valid on the next edge regardless of stall, and invalidate the skid buffer.
REQ-022 Redirect in FETCH with imem_ready=1: response dropped, pc<=redirect_pc, stay FETCH.
REQ-023 Redirect in FETCH with imem_ready=0: pending<=redirect_pc, go DISCARD.
REQ-024 DISCARD: on imem_ready=1 the response SHALL be dropped, pc<=pending, go FETCH; a further redirect in DISCARD overwrites pending, and if it coincides with imem_ready the new target SHALL be used.
REQ-025 Redirect in HOLD: pc<=redirect_pc, go FETCH.
REQ-026 If neither capture nor stall occurs in a cycle, if_valid SHALL fall to 0 (instruction consumed).
REQ-027 No instruction SHALL be delivered twice, skipped, or delivered after a redirect that precedes its capture.

Reset
REQ-028 While rst=1: state=IDLE, pc=RESET_PC, pending=0, skid invalid, imem_req=0, if_valid=0, if_pc=0, if_instr=0, applied asynchronously.
REQ-029 Reset mid-request SHALL abandon the outstanding access; the first request after release SHALL be to RESET_PC.

Verification
REQ-030 Release reset, imem_ready=1 always, stall=0 -> imem_req rises one cycle after release; if_pc sequence 0,4,8,12 on consecutive cycles with matching words.
REQ-031 Deliver pc 0x10, assert stall for 3 cycles with ready=1 -> 0x10 held on outputs, 0x14 parked in skid, imem_req=0 during HOLD; on release 0x14 then 0x18 follow with no gap or duplicate.
REQ-032 Request at 0x20 with ready=0, redirect to 0x100 -> stays DISCARD, addr 0x20 held; when ready=1 word dropped, next request addr 0x100, if_valid=0 until 0x100 returns.
REQ-033 Redirect to 0x203 coincident with ready=1 -> response dropped, next imem_addr=0x200.
REQ-034 Run from pc 32'hFFFF_FFF8 -> if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 Assert rst during DISCARD and during HOLD -> all outputs zero immediately; after release first imem_addr=RESET_PC.
